// File: rtl/video_src_arbiter.sv
// Frame-synchronous two-source video arbiter: grant moves only on vs rising edges,
// round-robin with a minimum-frame quota. Optional SYNC watchdog: define ARB_TIMEOUT_EN.
module video_src_arbiter #(
    parameter int unsigned RGB_W       = 24,
    parameter int unsigned TIMEOUT_CYC = 4000000
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [3:0]       frame_quota,
    input  logic             vs_a,
    input  logic             hs_a,
    input  logic             de_a,
    input  logic [RGB_W-1:0] rgb_a,
    input  logic             vs_b,
    input  logic             hs_b,
    input  logic             de_b,
    input  logic [RGB_W-1:0] rgb_b,
    output logic             vs_out,
    output logic             hs_out,
    output logic             de_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic [1:0]       grant,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    function automatic logic [1:0] f_onehot(input logic src);
        return (src == SRC_B) ? 2'b10 : 2'b01;
    endfunction

    state_t     r_state;
    logic       r_src;
    logic       r_last;
    logic [3:0] r_frame_cnt;
    logic       r_vs_a_d;
    logic       r_vs_b_d;

    state_t     w_state_nxt;
    logic       w_src_nxt;
    logic       w_last_nxt;
    logic [3:0] w_cnt_nxt;
    logic [1:0] w_grant_nxt;
    logic       w_pass;
    logic       w_pass_src;
    logic       w_timeout;

    logic       w_rise_a;
    logic       w_rise_b;
    logic       w_rise_own;
    logic       w_rise_oth;
    logic       w_req_own;
    logic       w_req_oth;
    logic [3:0] w_quota;
    logic       w_sync_expired;

    assign w_rise_a   = vs_a & ~r_vs_a_d;
    assign w_rise_b   = vs_b & ~r_vs_b_d;
    assign w_rise_own = (r_src == SRC_B) ? w_rise_b : w_rise_a;
    assign w_rise_oth = (r_src == SRC_B) ? w_rise_a : w_rise_b;
    assign w_req_own  = (r_src == SRC_B) ? req_b : req_a;
    assign w_req_oth  = (r_src == SRC_B) ? req_a : req_b;
    assign w_quota    = (frame_quota == 4'd0) ? 4'd1 : frame_quota;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] r_sync_cnt;

    // Cycles spent in SYNC; restarts from zero on every SYNC entry.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_sync_cnt <= '0;
        end else if (r_state != ST_SYNC) begin
            r_sync_cnt <= '0;
        end else begin
            r_sync_cnt <= r_sync_cnt + CNT_W'(1);
        end
    end

    assign w_sync_expired = (r_sync_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] w_unused_timeout_cyc;

    assign w_unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign w_sync_expired       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state     <= ST_IDLE;
            r_src       <= SRC_A;
            r_last      <= SRC_B;
            r_frame_cnt <= 4'd0;
            r_vs_a_d    <= 1'b0;
            r_vs_b_d    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_last      <= w_last_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_vs_a_d    <= vs_a;
            r_vs_b_d    <= vs_b;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_frame_cnt;
        w_grant_nxt = grant;
        w_pass      = 1'b0;
        w_pass_src  = r_src;
        w_timeout   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = 2'b00;
                if (req_a || req_b) begin
                    w_state_nxt = ST_SYNC;
                    w_src_nxt   = (req_a && req_b) ? ~r_last : req_b;
                    w_grant_nxt = f_onehot(w_src_nxt);
                end
            end

            ST_SYNC: begin
                if (!w_req_own) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                end else if (w_rise_own) begin
                    w_state_nxt = ST_PASS;
                    w_pass      = 1'b1;
                    w_cnt_nxt   = 4'd1;
                    w_last_nxt  = r_src;
                end else if (w_sync_expired) begin
                    // Hand priority to the other source on the next tie.
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                    w_last_nxt  = r_src;
                    w_timeout   = 1'b1;
                end
            end

            ST_PASS: begin
                w_pass = 1'b1;
                if (w_rise_own) begin
                    if (w_req_own && !(w_req_oth && (r_frame_cnt >= w_quota))) begin
                        w_cnt_nxt = (r_frame_cnt == 4'd15) ? 4'd15 : 4'(r_frame_cnt + 4'd1);
                    end else if (!w_req_own && !w_req_oth) begin
                        w_state_nxt = ST_IDLE;
                        w_pass      = 1'b0;
                        w_grant_nxt = 2'b00;
                    end else begin
                        // Owner's new frame is dropped whole; other source joins on its own vs.
                        w_pass      = 1'b0;
                        w_src_nxt   = ~r_src;
                        w_grant_nxt = f_onehot(~r_src);
                        if (w_rise_oth) begin
                            w_pass      = 1'b1;
                            w_pass_src  = ~r_src;
                            w_cnt_nxt   = 4'd1;
                            w_last_nxt  = ~r_src;
                        end else begin
                            w_state_nxt = ST_SYNC;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // Registered pipeline outputs: selected source or blank.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            vs_out      <= 1'b0;
            hs_out      <= 1'b0;
            de_out      <= 1'b0;
            rgb_out     <= '0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            grant       <= w_grant_nxt;
            timeout_err <= w_timeout;
            if (w_pass) begin
                vs_out  <= (w_pass_src == SRC_B) ? vs_b  : vs_a;
                hs_out  <= (w_pass_src == SRC_B) ? hs_b  : hs_a;
                de_out  <= (w_pass_src == SRC_B) ? de_b  : de_a;
                rgb_out <= (w_pass_src == SRC_B) ? rgb_b : rgb_a;
            end else begin
                vs_out  <= 1'b0;
                hs_out  <= 1'b0;
                de_out  <= 1'b0;
                rgb_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video_src_arbiter.sv
// Scoreboard bench for video_src_arbiter: stimulus pushes hand-planned expectations,
// a negedge monitor pops and compares one entry per clock.
module tb_video_src_arbiter;

    localparam int unsigned RGB_W = 24;
    localparam int          FL    = 32;
    localparam int unsigned TMO   = 100;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             req_a, req_b;
    logic [3:0]       frame_quota;
    logic             vs_a, hs_a, de_a;
    logic [RGB_W-1:0] rgb_a;
    logic             vs_b, hs_b, de_b;
    logic [RGB_W-1:0] rgb_b;
    logic             vs_out, hs_out, de_out;
    logic [RGB_W-1:0] rgb_out;
    logic [1:0]       grant;
    logic             timeout_err;

    typedef struct packed {
        logic             vs;
        logic             hs;
        logic             de;
        logic [RGB_W-1:0] rgb;
        logic [1:0]       grant;
        logic             tmo;
    } obs_t;

    typedef struct {
        obs_t want;
        int   scen;
        int   cyc;
    } sb_t;

    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   scen   = 0;
    int   off_a  = 10;
    int   off_b  = 26;
    logic en_a   = 1'b1;
    logic en_b   = 1'b1;

    video_src_arbiter #(.RGB_W(RGB_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_b(rst_b), .req_a(req_a), .req_b(req_b), .frame_quota(frame_quota),
        .vs_a(vs_a), .hs_a(hs_a), .de_a(de_a), .rgb_a(rgb_a),
        .vs_b(vs_b), .hs_b(hs_b), .de_b(de_b), .rgb_b(rgb_b),
        .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // 4 lines of 8 clocks; vs high for the first 2 clocks, first line has no de.
    function automatic void gen(input int p, input int frame, input logic [7:0] tag,
                                output logic vs, output logic hs, output logic de,
                                output logic [RGB_W-1:0] rgb);
        vs  = (p < 2);
        hs  = ((p % 8) == 0);
        de  = (p >= 8) && ((p % 8) >= 2) && ((p % 8) <= 6);
        rgb = {tag, 8'(frame), 8'(p)};
    endfunction

    // src: 0 blank, 1 expect A, 2 expect B (output registered from this cycle's inputs).
    task automatic step(input logic rst, input logic ra, input logic rb, input int c,
                        input int src, input logic [1:0] g, input logic tmo);
        obs_t e;
        if (c >= 0 && en_a) gen((c + off_a) % FL, (c + off_a) / FL, 8'hA5, vs_a, hs_a, de_a, rgb_a);
        else begin vs_a = 1'b0; hs_a = 1'b0; de_a = 1'b0; rgb_a = '0; end
        if (c >= 0 && en_b) gen((c + off_b) % FL, (c + off_b) / FL, 8'hB7, vs_b, hs_b, de_b, rgb_b);
        else begin vs_b = 1'b0; hs_b = 1'b0; de_b = 1'b0; rgb_b = '0; end
        rst_b = rst;
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        e = '0;
        if (src == 1) begin e.vs = vs_a; e.hs = hs_a; e.de = de_a; e.rgb = rgb_a; end
        if (src == 2) begin e.vs = vs_b; e.hs = hs_b; e.de = de_b; e.rgb = rgb_b; end
        e.grant = g;
        e.tmo   = tmo;
        sb.push_back('{want: e, scen: scen, cyc: c});
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, -1, 0, 2'b00, 1'b0);
    endtask

    always @(negedge clk) begin
        sb_t  s;
        obs_t act;
        if (sb.size() > 0) begin
            s   = sb.pop_front();
            act = {vs_out, hs_out, de_out, rgb_out, grant, timeout_err};
            checks++;
            if (act !== s.want) begin
                errors++;
                $display("FAIL scen%0d cyc%0d {vs,hs,de,rgb,grant,tmo}: got %h want %h",
                         s.scen, s.cyc, act, s.want);
            end
        end
    end

    initial begin
        int         src;
        logic [1:0] g;
        logic       t;
        rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0; frame_quota = 4'd1;
        vs_a = 1'b0; hs_a = 1'b0; de_a = 1'b0; rgb_a = '0;
        vs_b = 1'b0; hs_b = 1'b0; de_b = 1'b0; rgb_b = '0;

        // A only: grant after 1 clk, pass from A's vs at 22; req_a drops at 90, IDLE at 118.
        scen = 1; off_a = 10; off_b = 26; en_a = 1'b1; en_b = 1'b1; frame_quota = 4'd1;
        do_reset();
        for (int c = 0; c < 130; c++)
            step(1'b0, c < 90, 1'b0, c, (c >= 22 && c < 118) ? 1 : 0,
                 (c < 118) ? 2'b01 : 2'b00, 1'b0);

        // Both requesting, quota 2, offset phases (A rises 22+32k, B rises 6+32k).
        scen = 2; off_a = 10; off_b = 26; frame_quota = 4'd2;
        do_reset();
        for (int c = 0; c < 270; c++) begin
            if (c < 22)       src = 0;
            else if (c < 86)  src = 1;
            else if (c < 102) src = 0;
            else if (c < 166) src = 2;
            else if (c < 182) src = 0;
            else if (c < 246) src = 1;
            else if (c < 262) src = 0;
            else              src = 2;
            if (c < 86)       g = 2'b01;
            else if (c < 166) g = 2'b10;
            else if (c < 246) g = 2'b01;
            else              g = 2'b10;
            step(1'b0, 1'b1, 1'b1, c, src, g, 1'b0);
        end

        // Same phase, quota 1: seamless alternation; reset pulse at 100, then A preferred.
        scen = 3; off_a = 10; off_b = 10; frame_quota = 4'd1;
        do_reset();
        for (int c = 0; c < 130; c++) begin
            if (c < 22)        begin src = 0; g = 2'b01; end
            else if (c < 54)   begin src = 1; g = 2'b01; end
            else if (c < 86)   begin src = 2; g = 2'b10; end
            else if (c < 100)  begin src = 1; g = 2'b01; end
            else if (c == 100) begin src = 0; g = 2'b00; end
            else if (c < 118)  begin src = 0; g = 2'b01; end
            else               begin src = 1; g = 2'b01; end
            step(c == 100, 1'b1, 1'b1, c, src, g, 1'b0);
        end

        // Quota 0 behaves as 1: same alternation as above without the reset.
        scen = 4; off_a = 10; off_b = 10; frame_quota = 4'd0;
        do_reset();
        for (int c = 0; c < 100; c++) begin
            if (c < 22)       begin src = 0; g = 2'b01; end
            else if (c < 54)  begin src = 1; g = 2'b01; end
            else if (c < 86)  begin src = 2; g = 2'b10; end
            else              begin src = 1; g = 2'b01; end
            step(1'b0, 1'b1, 1'b1, c, src, g, 1'b0);
        end

        // B requests with vs_b stuck low; A joins at 50.
        scen = 5; off_a = 10; en_b = 1'b0; frame_quota = 4'd1;
        do_reset();
        for (int c = 0; c < 130; c++) begin
`ifdef ARB_TIMEOUT_EN
            if (c < 100)       g = 2'b10;
            else if (c == 100) g = 2'b00;
            else               g = 2'b01;
            t   = (c == 100);
            src = (c >= 118) ? 1 : 0;
`else
            g   = 2'b10;
            t   = 1'b0;
            src = 0;
`endif
            step(1'b0, c >= 50, 1'b1, c, src, g, t);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_src_arbiter.md
# video_src_arbiter

Frame-synchronous arbiter that shares one image-processing pipeline between two video sources (A, B). It sits between two timing/pixel sources and the shared processing chain. Grant changes only on frame boundaries, so the downstream pipeline only ever sees whole frames from a single source. It gives round-robin fairness with a per-grant minimum-frame quota.

## Interface
Parameters:
- RGB_W, 24, pixel bus width
- TIMEOUT_CYC, 4000000, SYNC-state timeout in clocks (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  pixel clock, all logic rising-edge
- rst_b  in  1  synchronous, active-high reset (polarity fixed despite name)
- req_a / req_b  in  1  level request for pipeline access
- frame_quota  in  4  minimum frames per grant before yielding; 0 treated as 1
- vs_a, hs_a, de_a  in  1  source A timing (vs active-high, rising edge = frame start)
- rgb_a  in  RGB_W  source A pixel
- vs_b, hs_b, de_b  in  1  source B timing
- rgb_b  in  RGB_W  source B pixel
- vs_out, hs_out, de_out  out  1  muxed timing to pipeline
- rgb_out  out  RGB_W  muxed pixel
- grant  out  2  one-hot {B,A}; 00 = none
- timeout_err  out  1  one-cycle pulse on SYNC timeout

## Operation
- vs_a/vs_b registered once; rise_x = vs_x & ~vs_x_d.
- States: IDLE, SYNC(target), PASS(owner). Round-robin pointer `last` holds the last granted source; reset value B, so A wins the first tie.
- IDLE: outputs blank (all 0), grant=00. If any req: pick the requester, or on a tie the one not equal to `last` -> SYNC(target), grant=target.
- SYNC: outputs blank. If target req low -> IDLE. Else on rise_target -> PASS(target); that same vs pulse is passed; frame_cnt=1; `last`=target.
- PASS: outputs register owner's vs/hs/de/rgb every cycle. Decisions are made only on rise_owner:
  - owner req low, other req high -> switch.
  - owner req low, other low -> IDLE; this frame is blanked.
  - owner req high, other high, frame_cnt >= max(frame_quota,1) -> switch.
  - otherwise stay; this frame is passed; frame_cnt++ saturating at 15.
- Switch from PASS: the owner's frame that just started is blanked. If rise_other occurs in the same cycle -> PASS(other) directly, passing the other's vs and setting frame_cnt=1. Otherwise -> SYNC(other).
- Requests are sampled only at the decision points above. A req drop mid-frame does not truncate the frame.
- Reset mid-frame: next cycle all outputs 0, state IDLE, `last`=B, frame_cnt=0.

## Timing
- Pass-through latency: 1 clk, input to output, for all timing and pixel signals.
- grant is registered and updates on the same edge as the state transition.
- Reset values: vs_out=hs_out=de_out=0, rgb_out=0, grant=00, timeout_err=0.
- Blanking to PASS is seamless: the first non-blank output cycle carries vs_out=1.
- The blank frame on a switch is not a truncation: outputs go 0 from the rise cycle onward, never partially.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A SYNC cycle counter, cleared on SYNC entry, counts up.
  - At TIMEOUT_CYC-1 with no rise_target: timeout_err pulses one cycle, state -> IDLE, `last`=target, so the other source gets priority on the next tie.
- ARB_TIMEOUT_EN undefined: SYNC waits indefinitely; timeout_err is tied 0; the port remains present.

## Test plan
- Reset, req_a=1 only, A frames of 30 lines -> grant=01 after 1 clk. Outputs stay 0 until A's next vs rise. Afterwards out equals A delayed exactly 1 clk.
- Both requesting from reset, frame_quota=2, A and B with offset vs phases -> A owns 2 full frames, 3rd A frame blanked, then B owns 2, alternating. No partial frame on de_out.
- A and B with identical vs phase, both requesting, quota=1 -> switch happens with no blank gap. vs_out is taken from B on the switch edge, then alternates every frame.
- req_a dropped mid-frame while passing A, req_b=0 -> current A frame completes. Next A vs is blanked, grant=00, state IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=100, req_b=1 with vs_b held low -> timeout_err pulses after 100 clks in SYNC, grant=00. With req_a=1 too, the next grant goes to A.
- Assert rst_b for 1 clk mid-PASS -> all outputs 0 next cycle. Re-arbitration starts with A preferred.
